// File: rtl/prio_enc_pkg.sv
// Shared types and reference encoding for the 8-to-3 priority encoder.
package prio_enc_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OUT_W = $clog2(WIDTH);

  typedef struct packed {
    logic [OUT_W-1:0] idx;
    logic             valid;
    logic [WIDTH-1:0] onehot;
    logic             multi;
  } prio_res_t;

  // Reference encoding: MSB-down scan and explicit popcount, deliberately a
  // different formulation from the hardware core.
  function automatic prio_res_t prio_ref(input logic [WIDTH-1:0] v);
    prio_res_t   r;
    int unsigned cnt;
    r   = '0;
    cnt = 0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (v[i] && !r.valid) begin
        r.valid = 1'b1;
        r.idx   = OUT_W'(i);
      end
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) cnt++;
    end
    r.onehot = r.valid ? (WIDTH'(1) << r.idx) : '0;
    r.multi  = (cnt >= 2);
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational, width-generic highest-index-wins priority encoder.
module prio_enc_core #(
  parameter int unsigned Width = 8,
  localparam int unsigned IdxW = $clog2(Width)
) (
  input  logic [Width-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o,
  output logic [Width-1:0] onehot_o,
  output logic             multi_o
);

  logic [IdxW-1:0] idx;
  logic            hit;

  // Scan upward from the LSB; the last set bit seen is the highest and wins.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (req_i[i]) begin
        idx = IdxW'(i);
        hit = 1'b1;
      end
    end
  end

  assign idx_o    = idx;
  assign any_o    = hit;
  assign onehot_o = hit ? (Width'(1) << idx) : '0;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o  = |(req_i & (req_i - Width'(1)));

endmodule

// File: rtl/prio_encoder_8to3.sv
// Registered priority encoder: one output stage over prio_enc_core.
module prio_encoder_8to3
  import prio_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] onehot,
  output logic             multi
);

  prio_res_t res_d, res_q;
  logic      out_valid_q;

  prio_enc_core #(
    .Width (WIDTH)
  ) u_core (
    .req_i    (in),
    .idx_o    (res_d.idx),
    .any_o    (res_d.valid),
    .onehot_o (res_d.onehot),
    .multi_o  (res_d.multi)
  );

  // Capture the encoding on accepted vectors, hold otherwise; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out       = res_q.idx;
  assign valid     = res_q.valid;
  assign onehot    = res_q.onehot;
  assign multi     = res_q.multi;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Self-checking bench for prio_encoder_8to3 with a scoreboard queue.
module tb_prio_encoder_8to3;
  import prio_enc_pkg::*;

  typedef struct packed {
    logic [2:0] out;
    logic       valid;
    logic       out_valid;
    logic [7:0] onehot;
    logic       multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
  logic       out_valid;
  logic [7:0] onehot;
  logic       multi;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t hold;

  prio_encoder_8to3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .out       (out),
    .valid     (valid),
    .out_valid (out_valid),
    .onehot    (onehot),
    .multi     (multi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] o, input logic vl, input logic ov,
                              input logic [7:0] oh, input logic m);
    exp_t e;
    e.out = o; e.valid = vl; e.out_valid = ov; e.onehot = oh; e.multi = m;
    return e;
  endfunction

  function automatic exp_t model(input logic r, input logic iv, input logic [7:0] v);
    exp_t      e;
    prio_res_t p;
    if (!r) begin
      e = '0;
    end else if (iv) begin
      p = prio_ref(v);
      e = mk(p.idx, p.valid, 1'b1, p.onehot, p.multi);
    end else begin
      e = hold;
      e.out_valid = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle with an explicit expectation, then compare after the edge.
  task automatic tick_exp(input logic r, input logic iv, input logic [7:0] v, input exp_t e);
    exp_t x;
    rst_n = r; in_valid = iv; in = v;
    hold = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check_eq("out", 32'(out), 32'(x.out));
      check_eq("valid", 32'(valid), 32'(x.valid));
      check_eq("out_valid", 32'(out_valid), 32'(x.out_valid));
      check_eq("onehot", 32'(onehot), 32'(x.onehot));
      check_eq("multi", 32'(multi), 32'(x.multi));
    end
  endtask

  task automatic tick(input logic r, input logic iv, input logic [7:0] v);
    tick_exp(r, iv, v, model(r, iv, v));
  endtask

  logic [7:0] singles [6] = '{8'h01, 8'h04, 8'h10, 8'h80, 8'h40, 8'h08};
  logic [2:0] idxs    [6] = '{3'd0, 3'd2, 3'd4, 3'd7, 3'd6, 3'd3};

  initial begin
    logic       r;
    logic       iv;
    logic [7:0] v;
    hold = '0;
    rst_n = 1'b0; in_valid = 1'b0; in = 8'h00;
    @(posedge clk);
    #1;

    // Reset, including an all-ones request presented while reset is held.
    tick_exp(1'b0, 1'b0, 8'h00, mk(3'd0, 1'b0, 1'b0, 8'h00, 1'b0));
    tick_exp(1'b0, 1'b0, 8'h00, mk(3'd0, 1'b0, 1'b0, 8'h00, 1'b0));
    tick_exp(1'b0, 1'b1, 8'hFF, mk(3'd0, 1'b0, 1'b0, 8'h00, 1'b0));

    // Zero vector still pulses out_valid.
    tick_exp(1'b1, 1'b1, 8'h00, mk(3'd0, 1'b0, 1'b1, 8'h00, 1'b0));

    // Back-to-back single-bit vectors.
    for (int i = 0; i < 6; i++) begin
      tick_exp(1'b1, 1'b1, singles[i], mk(idxs[i], 1'b1, 1'b1, singles[i], 1'b0));
    end

    // Multiple bits: highest wins, lower bits ignored.
    tick_exp(1'b1, 1'b1, 8'hE0, mk(3'd7, 1'b1, 1'b1, 8'h80, 1'b1));

    // Hold while in_valid is low, even with a changed input.
    tick_exp(1'b1, 1'b1, 8'h10, mk(3'd4, 1'b1, 1'b1, 8'h10, 1'b0));
    tick_exp(1'b1, 1'b0, 8'hFF, mk(3'd4, 1'b1, 1'b0, 8'h10, 1'b0));
    tick_exp(1'b1, 1'b0, 8'hFF, mk(3'd4, 1'b1, 1'b0, 8'h10, 1'b0));

    // Random traffic with sporadic and one forced mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      r  = !((i == 500) || ($urandom_range(0, 63) == 0));
      iv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       v = 8'h01 << $urandom_range(0, 7);
        1:       v = (i % 50 == 0) ? 8'h00 : 8'($urandom);
        default: v = 8'($urandom);
      endcase
      tick(r, iv, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
